// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage WISC pipeline.
//
// Purpose:
//   Detects load-use and flag-dependency hazards on the instruction in ID. It drives the
//   PC / IF-ID stall, the IF-ID flush and the ID-EX bubble controls, and it sequences the
//   HLT drain. It also tracks a valid bit and an instruction tag for every stage, and keeps
//   saturating counts of hazard stalls and flushes.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   id_src1/2         ID source register indices; *_used qualifies each read
//   id_branch         ID instruction is a conditional branch (reads flags)
//   id_br_taken       branch in ID resolved taken
//   id_hlt            ID instruction is HLT
//   ex_mem_read       EX instruction is a load
//   ex_dst            EX destination register
//   ex_flag_write     EX instruction updates flags
//   pc_stall          hold PC
//   if_id_stall       hold IF/ID register
//   if_id_flush       clear IF/ID register
//   id_ex_bubble      insert NOP into ID/EX
//   stage_valid       valid bits {wb,mem,ex,id,if}
//   stage_tag         per-stage tags, IF in the low slice and WB in the top slice
//   halted            HLT has reached WB
//   stall_cnt         saturating count of hazard-stall cycles
//   flush_cnt         saturating count of IF/ID flushes
module pipeline_ctrl #(
  parameter int unsigned TAG_W = 7,
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_src1,
  input  logic [REG_W-1:0]   id_src2,
  input  logic               id_src1_used,
  input  logic               id_src2_used,
  input  logic               id_branch,
  input  logic               id_br_taken,
  input  logic               id_hlt,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_dst,
  input  logic               ex_flag_write,
  output logic               pc_stall,
  output logic               if_id_stall,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic [4:0]         stage_valid,
  output logic [5*TAG_W-1:0] stage_tag,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Stage slot indices into the valid and tag vectors.
  localparam int unsigned SIf  = 0;
  localparam int unsigned SId  = 1;
  localparam int unsigned SEx  = 2;
  localparam int unsigned SMem = 3;
  localparam int unsigned SWb  = 4;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             valid_q, valid_d;
  logic [4:0][TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]       next_tag_q, next_tag_d;
  logic                   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic id_live;
  logic src1_hit;
  logic src2_hit;
  logic lu;
  logic fl;
  logic haz;
  logic br_flush;
  logic hlt_go;

  // Hazard detection. Everything is qualified by a live instruction in ID during RUN, so a
  // bubble in ID never stalls, flushes or halts. Reset masks every decision.
  always_comb begin
    id_live  = valid_q[SId] && (state_q == StRun) && !rst;
    src1_hit = id_src1_used && (id_src1 == ex_dst);
    src2_hit = id_src2_used && (id_src2 == ex_dst);
    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    lu       = ex_mem_read && valid_q[SEx] && (ex_dst != '0) && (src1_hit || src2_hit);
    fl       = id_branch && ex_flag_write && valid_q[SEx];
    haz      = id_live && (lu || fl);
    // Lower-priority actions in ID wait for the hazard to clear and are then re-evaluated.
    br_flush = id_live && !haz && id_br_taken;
    hlt_go   = id_live && !haz && !id_br_taken && id_hlt;
  end

  // Pipeline control outputs.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          pc_stall     = haz;
          if_id_stall  = haz;
          id_ex_bubble = haz;
          if_id_flush  = br_flush;
        end
        StDrain: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
        end
        StHalted: begin
          pc_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state, valid/tag tracking and counters.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    next_tag_d  = next_tag_q;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      StRun: begin
        if (haz) begin
          // IF and ID hold; EX becomes a bubble and keeps its stale tag; MEM/WB advance.
          valid_d = {valid_q[SMem], valid_q[SEx], 1'b0, valid_q[SId], valid_q[SIf]};
          tag_d   = {tag_q[SMem], tag_q[SEx], tag_q[SEx], tag_q[SId], tag_q[SIf]};
        end else begin
          valid_d    = {valid_q[SMem], valid_q[SEx], valid_q[SId], valid_q[SIf], 1'b1};
          tag_d      = {tag_q[SMem], tag_q[SEx], tag_q[SId], tag_q[SIf], next_tag_q};
          next_tag_d = next_tag_q + 1'b1;
          // A taken branch squashes the instruction fetched behind it as it enters ID.
          if (br_flush) begin
            valid_d[SId] = 1'b0;
          end
          // HLT moves on to EX; everything fetched behind it is discarded.
          if (hlt_go) begin
            state_d      = StDrain;
            valid_d[SIf] = 1'b0;
            valid_d[SId] = 1'b0;
            drain_cnt_d  = 1'b0;
          end
        end
      end
      StDrain: begin
        // Front end stays empty while HLT walks EX -> MEM -> WB.
        valid_d = {valid_q[SMem], valid_q[SEx], 3'b000};
        tag_d   = {tag_q[SMem], tag_q[SEx], tag_q[SId], tag_q[SId], tag_q[SIf]};
        // HLT sits in EX on the first drain cycle and MEM on the second, so the
        // second drain cycle's edge moves it into WB together with the HALTED state.
        if (drain_cnt_q) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      StHalted: begin
        valid_d = '0;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (haz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (br_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      valid_q     <= '0;
      tag_q       <= '0;
      next_tag_q  <= '0;
      drain_cnt_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      next_tag_q  <= next_tag_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stage_valid = valid_q;
  assign stage_tag   = tag_q;
  assign halted      = (state_q == StHalted);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl.
// u0 uses default parameters; u1 uses TAG_W=3, CNT_W=4 for tag wrap and counter saturation.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  logic rst2;

  logic [3:0] id_src1, id_src2, ex_dst;
  logic       id_src1_used, id_src2_used, id_branch, id_br_taken, id_hlt;
  logic       ex_mem_read, ex_flag_write;

  logic        u0_pc_stall, u0_if_id_stall, u0_if_id_flush, u0_id_ex_bubble, u0_halted;
  logic [4:0]  u0_valid;
  logic [34:0] u0_tag;
  logic [15:0] u0_stall_cnt, u0_flush_cnt;

  logic [3:0] s_ex_dst, s_id_src2;
  logic       s_ex_mem_read, s_id_src2_used;

  logic        u1_pc_stall, u1_if_id_stall, u1_if_id_flush, u1_id_ex_bubble, u1_halted;
  logic [4:0]  u1_valid;
  logic [14:0] u1_tag;
  logic [3:0]  u1_stall_cnt, u1_flush_cnt;

  int total;
  int bad;

  pipeline_ctrl u0 (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_branch    (id_branch),
    .id_br_taken  (id_br_taken),
    .id_hlt       (id_hlt),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .ex_flag_write(ex_flag_write),
    .pc_stall     (u0_pc_stall),
    .if_id_stall  (u0_if_id_stall),
    .if_id_flush  (u0_if_id_flush),
    .id_ex_bubble (u0_id_ex_bubble),
    .stage_valid  (u0_valid),
    .stage_tag    (u0_tag),
    .halted       (u0_halted),
    .stall_cnt    (u0_stall_cnt),
    .flush_cnt    (u0_flush_cnt)
  );

  pipeline_ctrl #(
    .TAG_W(3),
    .REG_W(4),
    .CNT_W(4)
  ) u1 (
    .clk          (clk),
    .rst          (rst2),
    .id_src1      (4'd0),
    .id_src2      (s_id_src2),
    .id_src1_used (1'b0),
    .id_src2_used (s_id_src2_used),
    .id_branch    (1'b0),
    .id_br_taken  (1'b0),
    .id_hlt       (1'b0),
    .ex_mem_read  (s_ex_mem_read),
    .ex_dst       (s_ex_dst),
    .ex_flag_write(1'b0),
    .pc_stall     (u1_pc_stall),
    .if_id_stall  (u1_if_id_stall),
    .if_id_flush  (u1_if_id_flush),
    .id_ex_bubble (u1_id_ex_bubble),
    .stage_valid  (u1_valid),
    .stage_tag    (u1_tag),
    .halted       (u1_halted),
    .stall_cnt    (u1_stall_cnt),
    .flush_cnt    (u1_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  function automatic logic [6:0] t0(input int s);
    return u0_tag[s*7 +: 7];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    total = 0;
    bad   = 0;
    rst = 1'b1; rst2 = 1'b1;
    id_src1 = '0; id_src2 = '0; ex_dst = '0;
    id_src1_used = 1'b0; id_src2_used = 1'b0; id_branch = 1'b0; id_br_taken = 1'b0;
    id_hlt = 1'b0; ex_mem_read = 1'b0; ex_flag_write = 1'b0;
    s_ex_dst = '0; s_id_src2 = '0; s_ex_mem_read = 1'b0; s_id_src2_used = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_valid", 64'(u0_valid), 64'(0));
    check("rst_tags", 64'(u0_tag), 64'(0));
    check("rst_halted", 64'(u0_halted), 64'(0));
    check("rst_stall_cnt", 64'(u0_stall_cnt), 64'(0));
    check("rst_flush_cnt", 64'(u0_flush_cnt), 64'(0));
    check("rst_pc_stall", 64'(u0_pc_stall), 64'(0));

    // Clean fill: valid walks 00001 -> 11111, WB tag 0 after edge 5.
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = (k >= 5) ? 31 : (1 << k) - 1;
      check("walk_valid", 64'(u0_valid), 64'(e));
      if (k >= 5) check("walk_wb_tag", 64'(t0(4)), 64'(k - 5));
    end
    // Now IF5 ID4 EX3 MEM2 WB1, next tag 6.

    // Load-use on src1 = R3.
    ex_mem_read = 1'b1; ex_dst = 4'd3; id_src1 = 4'd3; id_src1_used = 1'b1;
    #1;
    check("lu_pc_stall", 64'(u0_pc_stall), 64'(1));
    check("lu_if_id_stall", 64'(u0_if_id_stall), 64'(1));
    check("lu_bubble", 64'(u0_id_ex_bubble), 64'(1));
    check("lu_flush", 64'(u0_if_id_flush), 64'(0));
    tick();
    check("lu_valid", 64'(u0_valid), 64'(5'h1B));
    check("lu_id_tag", 64'(t0(1)), 64'(4));
    check("lu_if_tag", 64'(t0(0)), 64'(5));
    check("lu_stall_cnt", 64'(u0_stall_cnt), 64'(1));
    check("lu_one_cycle", 64'(u0_pc_stall), 64'(0));

    // Load to R0 is never a hazard.
    ex_dst = 4'd0; id_src1 = 4'd0;
    tick();
    check("r0_valid", 64'(u0_valid), 64'(5'h17));
    #1;
    check("r0_pc_stall", 64'(u0_pc_stall), 64'(0));
    // Matching index but src1 not used.
    ex_dst = 4'd3; id_src1 = 4'd3; id_src1_used = 1'b0;
    #1;
    check("unused_bubble", 64'(u0_id_ex_bubble), 64'(0));
    tick();
    check("neg_stall_cnt", 64'(u0_stall_cnt), 64'(1));
    ex_mem_read = 1'b0; ex_dst = '0; id_src1 = '0;
    tick();
    // Now IF8 ID7 EX6 MEM5 WB4, all valid.
    check("pre_br_valid", 64'(u0_valid), 64'(5'h1F));

    // Taken branch, no hazard.
    id_br_taken = 1'b1;
    #1;
    check("br_flush", 64'(u0_if_id_flush), 64'(1));
    check("br_pc_stall", 64'(u0_pc_stall), 64'(0));
    tick();
    check("br_valid", 64'(u0_valid), 64'(5'h1D));
    check("br_flush_cnt", 64'(u0_flush_cnt), 64'(1));
    check("br_id_dead", 64'(u0_if_id_flush), 64'(0));
    check("br_wb_tag", 64'(t0(4)), 64'(5));
    id_br_taken = 1'b0;
    tick();
    tick();
    // Now IF11 ID10 EX9 MEM(bubble) WB7.
    check("pre_fl_valid", 64'(u0_valid), 64'(5'h17));

    // Taken branch with flag dependency: stall first, flush one cycle later.
    id_branch = 1'b1; ex_flag_write = 1'b1; id_br_taken = 1'b1;
    #1;
    check("fl_pc_stall", 64'(u0_pc_stall), 64'(1));
    check("fl_no_flush", 64'(u0_if_id_flush), 64'(0));
    tick();
    check("fl_valid", 64'(u0_valid), 64'(5'h0B));
    check("fl_stall_cnt", 64'(u0_stall_cnt), 64'(2));
    check("fl_flush_cnt", 64'(u0_flush_cnt), 64'(1));
    check("fl_id_tag", 64'(t0(1)), 64'(10));
    check("fl_deferred_flush", 64'(u0_if_id_flush), 64'(1));
    tick();
    check("fl2_valid", 64'(u0_valid), 64'(5'h15));
    check("fl2_flush_cnt", 64'(u0_flush_cnt), 64'(2));
    id_branch = 1'b0; ex_flag_write = 1'b0; id_br_taken = 1'b0;

    // HLT drain with tag 9 in ID.
    rst = 1'b1;
    tick();
    check("rst2_stall_cnt", 64'(u0_stall_cnt), 64'(0));
    check("rst2_flush_cnt", 64'(u0_flush_cnt), 64'(0));
    check("rst2_valid", 64'(u0_valid), 64'(0));
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    check("hlt_id_tag", 64'(t0(1)), 64'(9));
    id_hlt = 1'b1;
    #1;
    check("hlt_run_pc_stall", 64'(u0_pc_stall), 64'(0));
    tick();
    id_hlt = 1'b0;
    check("drain_pc_stall", 64'(u0_pc_stall), 64'(1));
    check("drain_if_id_stall", 64'(u0_if_id_stall), 64'(1));
    check("drain_front_valid", 64'(u0_valid[1:0]), 64'(0));
    check("drain_ex_tag", 64'(t0(2)), 64'(9));
    check("drain_ex_valid", 64'(u0_valid[2]), 64'(1));
    check("drain_halted", 64'(u0_halted), 64'(0));
    tick();
    check("drain2_mem_tag", 64'(t0(3)), 64'(9));
    check("drain2_halted", 64'(u0_halted), 64'(0));
    tick();
    check("halt_halted", 64'(u0_halted), 64'(1));
    check("halt_wb_valid", 64'(u0_valid[4]), 64'(1));
    check("halt_wb_tag", 64'(t0(4)), 64'(9));
    check("halt_pc_stall", 64'(u0_pc_stall), 64'(1));
    tick();
    check("halt_valids", 64'(u0_valid), 64'(0));
    check("halt_stays", 64'(u0_halted), 64'(1));
    check("halt_pc_stall2", 64'(u0_pc_stall), 64'(1));

    // Reset during DRAIN.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    id_hlt = 1'b1;
    tick();
    id_hlt = 1'b0;
    check("rd_drain_pc_stall", 64'(u0_pc_stall), 64'(1));
    rst = 1'b1;
    #1;
    check("rd_rst_pc_stall", 64'(u0_pc_stall), 64'(0));
    check("rd_rst_if_id_stall", 64'(u0_if_id_stall), 64'(0));
    tick();
    check("rd_valid", 64'(u0_valid), 64'(0));
    check("rd_halted", 64'(u0_halted), 64'(0));
    rst = 1'b0;
    tick();
    check("rd_run_valid", 64'(u0_valid), 64'(1));
    check("rd_run_pc_stall", 64'(u0_pc_stall), 64'(0));
    tick(); tick(); tick();
    check("rd_no_halt", 64'(u0_halted), 64'(0));

    // Tag wrap on the 3-bit instance.
    tick();
    rst2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("wrap_if_tag", 64'(u1_tag[2:0]), 64'((k - 1) % 8));
    end

    // Repeated load-use on src2 until the 4-bit stall counter saturates.
    s_ex_mem_read = 1'b1; s_ex_dst = 4'd5; s_id_src2 = 4'd5; s_id_src2_used = 1'b1;
    #1;
    check("sat_bubble", 64'(u1_id_ex_bubble), 64'(1));
    for (int k = 0; k < 8; k++) tick();
    check("sat_mid_cnt", 64'(u1_stall_cnt), 64'(4));
    for (int k = 0; k < 32; k++) tick();
    check("sat_cnt", 64'(u1_stall_cnt), 64'(15));
    tick(); tick();
    check("sat_hold", 64'(u1_stall_cnt), 64'(15));
    s_ex_mem_read = 1'b0; s_id_src2_used = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
